// File: rtl/sd_boot_pkg.sv
// sd_boot_pkg: shared types and constants for the SD boot loader.
//   - boot FSM state encoding
//   - sdhci register offsets and STATUS bit positions
//   - block size and EVB write-mask encodings
`ifndef EVB_MASK_W
`define EVB_MASK_W 2'b11
`endif
`ifndef EVB_MASK_DUMMY
`define EVB_MASK_DUMMY 2'b00
`endif

package sd_boot_pkg;

  typedef enum logic [3:0] {
    RESET,
    EN_WR,
    POLL_HI,
    POLL_LO,
    ADDR_WR,
    READ_WR,
    DONE,
    ERR_WR,
    FAIL
  } boot_state_e;

  localparam logic [3:0] REG_ADDRESS = 4'd0;
  localparam logic [3:0] REG_STATUS  = 4'd1;
  localparam logic [3:0] REG_READ    = 4'd2;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_EN   = 1;

  localparam logic [15:0] BLOCK_BYTES = 16'h0200;

  localparam logic [1:0] MASK_W     = `EVB_MASK_W;
  localparam logic [1:0] MASK_DUMMY = `EVB_MASK_DUMMY;

endpackage

// File: rtl/sd_boot_loader_if.sv
// sd_boot_loader_if: EVB register command bus.
//   request/addr/wr_mask/wr_data : master -> slave, held until finish
//   finish                       : slave -> master, one-cycle completion
//   rd_data                      : slave -> master, valid with finish
interface sd_boot_loader_if;
  logic        request;
  logic [3:0]  addr;
  logic [1:0]  wr_mask;
  logic [31:0] wr_data;
  logic        finish;
  logic [31:0] rd_data;

  modport master (
    output request, addr, wr_mask, wr_data,
    input  finish, rd_data
  );

  modport slave (
    input  request, addr, wr_mask, wr_data,
    output finish, rd_data
  );
endinterface

// File: rtl/sd_boot_loader_cmd_master.sv
// evb_cmd_master: issues one EVB register read or write at a time.
//   clk, rst        : clock, synchronous active-high reset
//   start           : launch a command when idle (ignored while busy)
//   cmd_addr/mask/data : command fields, captured on launch
//   request/addr/wr_mask/wr_data : registered bus outputs
//   finish, rd_data : bus completion and read data
//   done            : completion of the outstanding command
//   done_rd_data    : read data, valid together with done
//   busy            : a command is outstanding
module evb_cmd_master
  import sd_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  cmd_addr,
  input  logic [1:0]  cmd_wr_mask,
  input  logic [31:0] cmd_wr_data,
  output logic        request,
  output logic [3:0]  addr,
  output logic [1:0]  wr_mask,
  output logic [31:0] wr_data,
  input  logic        finish,
  input  logic [31:0] rd_data,
  output logic        done,
  output logic [31:0] done_rd_data,
  output logic        busy
);

  logic        request_reg;
  logic [3:0]  addr_reg;
  logic [1:0]  wr_mask_reg;
  logic [31:0] wr_data_reg;

  // A launch is only accepted while request is low, so the cycle after a
  // finish is always idle on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      request_reg <= 1'b0;
      addr_reg    <= 4'd0;
      wr_mask_reg <= MASK_DUMMY;
      wr_data_reg <= 32'd0;
    end else if (request_reg) begin
      if (finish) request_reg <= 1'b0;
    end else if (start) begin
      request_reg <= 1'b1;
      addr_reg    <= cmd_addr;
      wr_mask_reg <= cmd_wr_mask;
      wr_data_reg <= cmd_wr_data;
    end
  end

  assign request      = request_reg;
  assign addr         = addr_reg;
  assign wr_mask      = wr_mask_reg;
  assign wr_data      = wr_data_reg;
  assign done         = request_reg & finish;
  assign done_rd_data = rd_data;
  assign busy         = request_reg;

endmodule

// File: rtl/sd_boot_loader.sv
// sd_boot_loader: boot-time sequencer in front of sdhci.
//   Enables the card, waits for init, reads BLOCKS consecutive blocks into
//   TCM starting at LOAD_BASE, then hands the command port to the CPU.
//   clk, rst   : clock, synchronous active-high reset
//   sd_cmd     : command bus towards sdhci (master side)
//   host_cmd   : command bus from the CPU (slave side), stalled during boot
//   cpu_hold   : high until boot ends (pass or fail)
//   boot_done  : sticky, all blocks loaded
//   boot_error : sticky, a poll phase timed out
module sd_boot_loader
  import sd_boot_pkg::*;
#(
  parameter int          BLOCKS      = 64,
  parameter logic [31:0] START_BLOCK = 32'h0,
  parameter logic [15:0] LOAD_BASE   = 16'h0000,
  parameter logic [31:0] TIMEOUT     = 32'd50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  sd_boot_loader_if.master  sd_cmd,
  sd_boot_loader_if.slave   host_cmd,
  output logic              cpu_hold,
  output logic              boot_done,
  output logic              boot_error
);

  boot_state_e state_reg, state_next;
  logic        phase_reg, phase_next;          // 0: init phase, 1: read phase
  logic [15:0] base_reg, base_next;
  logic [7:0]  remaining_reg, remaining_next;
  logic [31:0] timer_reg, timer_next;
  logic        cpu_hold_reg, boot_done_reg, boot_error_reg;

  logic        start;
  logic [3:0]  cmd_addr;
  logic [1:0]  cmd_wr_mask;
  logic [31:0] cmd_wr_data;
  logic        mst_request;
  logic [3:0]  mst_addr;
  logic [1:0]  mst_wr_mask;
  logic [31:0] mst_wr_data;
  logic        mst_done;
  logic [31:0] mst_rd_data;
  logic        mst_busy;
  logic        in_poll;
  logic        timeout_hit;
  logic        host_mode;

  evb_cmd_master u_master (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cmd_addr     (cmd_addr),
    .cmd_wr_mask  (cmd_wr_mask),
    .cmd_wr_data  (cmd_wr_data),
    .request      (mst_request),
    .addr         (mst_addr),
    .wr_mask      (mst_wr_mask),
    .wr_data      (mst_wr_data),
    .finish       (sd_cmd.finish),
    .rd_data      (sd_cmd.rd_data),
    .done         (mst_done),
    .done_rd_data (mst_rd_data),
    .busy         (mst_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RESET;
      phase_reg      <= 1'b0;
      base_reg       <= LOAD_BASE;
      remaining_reg  <= 8'(BLOCKS);
      timer_reg      <= 32'd0;
      cpu_hold_reg   <= 1'b1;
      boot_done_reg  <= 1'b0;
      boot_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      base_reg       <= base_next;
      remaining_reg  <= remaining_next;
      timer_reg      <= timer_next;
      // Flags follow the state register so boot_done/boot_error and
      // cpu_hold all change on the edge that enters the terminal state.
      cpu_hold_reg   <= !(state_next == DONE || state_next == FAIL);
      boot_done_reg  <= (state_next == DONE);
      boot_error_reg <= (state_next == FAIL);
    end
  end

  assign in_poll = (state_reg == POLL_HI) || (state_reg == POLL_LO);
  // A timeout is only acted on between polls; an outstanding poll is
  // always allowed to finish first.
  assign timeout_hit = in_poll && !mst_busy && (timer_reg >= TIMEOUT);

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    base_next      = base_reg;
    remaining_next = remaining_reg;
    start          = 1'b0;
    cmd_addr       = REG_STATUS;
    cmd_wr_mask    = MASK_DUMMY;
    cmd_wr_data    = 32'd0;

    case (state_reg)
      RESET: state_next = EN_WR;

      EN_WR: begin
        start       = 1'b1;
        cmd_wr_mask = MASK_W;
        cmd_wr_data = 32'h2;
        if (mst_done) begin
          phase_next = 1'b0;
          state_next = POLL_HI;
        end
      end

      POLL_HI: begin
        start = !timeout_hit;
        if (mst_done) begin
          if (mst_rd_data[STATUS_BUSY]) state_next = POLL_LO;
        end else if (timeout_hit) begin
          state_next = ERR_WR;
        end
      end

      POLL_LO: begin
        start = !timeout_hit;
        if (mst_done) begin
          if (!mst_rd_data[STATUS_BUSY]) begin
            if (!phase_reg) begin
              state_next = ADDR_WR;
            end else begin
              remaining_next = remaining_reg - 8'd1;
              state_next     = (remaining_reg == 8'd1) ? DONE : READ_WR;
            end
          end
        end else if (timeout_hit) begin
          state_next = ERR_WR;
        end
      end

      ADDR_WR: begin
        start       = 1'b1;
        cmd_addr    = REG_ADDRESS;
        cmd_wr_mask = MASK_W;
        cmd_wr_data = START_BLOCK;
        if (mst_done) state_next = READ_WR;
      end

      READ_WR: begin
        // sdhci advances its block address itself; only the TCM target moves.
        start       = 1'b1;
        cmd_addr    = REG_READ;
        cmd_wr_mask = MASK_W;
        cmd_wr_data = {16'h0, base_reg};
        if (mst_done) begin
          base_next  = base_reg + BLOCK_BYTES;
          phase_next = 1'b1;
          state_next = POLL_HI;
        end
      end

      ERR_WR: begin
        start       = 1'b1;
        cmd_wr_mask = MASK_W;
        cmd_wr_data = 32'h0;
        if (mst_done) state_next = FAIL;
      end

      DONE:    state_next = DONE;
      FAIL:    state_next = FAIL;
      default: state_next = RESET;
    endcase
  end

  // Poll timer restarts on every state change and only counts in poll states.
  always_comb begin
    if (state_next != state_reg) timer_next = 32'd0;
    else if (in_poll)            timer_next = timer_reg + 32'd1;
    else                         timer_next = timer_reg;
  end

  assign host_mode = !cpu_hold_reg;

  always_comb begin
    if (host_mode) begin
      sd_cmd.request   = host_cmd.request;
      sd_cmd.addr      = host_cmd.addr;
      sd_cmd.wr_mask   = host_cmd.wr_mask;
      sd_cmd.wr_data   = host_cmd.wr_data;
      host_cmd.finish  = sd_cmd.finish;
      host_cmd.rd_data = sd_cmd.rd_data;
    end else begin
      sd_cmd.request   = mst_request;
      sd_cmd.addr      = mst_addr;
      sd_cmd.wr_mask   = mst_wr_mask;
      sd_cmd.wr_data   = mst_wr_data;
      host_cmd.finish  = 1'b0;
      host_cmd.rd_data = 32'd0;
    end
  end

  assign cpu_hold   = cpu_hold_reg;
  assign boot_done  = boot_done_reg;
  assign boot_error = boot_error_reg;

endmodule
